// File: rtl/parity_unit.sv
// parity_unit
//   Serial parity generator/checker. A word is accepted in IDLE, shifted out
//   LSB-first through a parity accumulator over DATA_WIDTH cycles, and the
//   result is presented in DONE until the consumer takes it.
//
//   Ports:
//     i_clk, i_rst        clock, synchronous active-high reset
//     i_valid / o_ready   word handshake (o_ready = IDLE)
//     i_word              data word, DATA_WIDTH bits
//     i_parity_bit        received parity bit to check
//     i_mode              00 even, 01 odd, 10 mark, 11 space
//     o_valid / i_ready   result handshake (o_valid = DONE)
//     o_parity, o_error   expected parity, mismatch against received bit
//     i_clr_count         clear the error counter
//     o_err_count         saturating parity error count
//
//   Build option: define PARITY_ERR_CNT_EN to include the error counter.
//   Without it o_err_count is tied to 0 and i_clr_count is ignored.
module parity_unit #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_WIDTH-1:0]    i_word,
  input  logic                     i_parity_bit,
  input  logic [1:0]               i_mode,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_parity,
  output logic                     o_error,
  input  logic                     i_clr_count,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sr;
  logic                  r_acc;
  logic [CW-1:0]         r_cnt;
  logic                  r_pbit;
  logic [1:0]            r_mode;
  logic                  r_parity;
  logic                  r_error;
  logic                  w_par;

  assign o_ready  = (r_state == S_IDLE);
  assign o_valid  = (r_state == S_DONE);
  assign o_parity = r_parity;
  assign o_error  = r_error;

  // Mode applied to the finished accumulator.
  always_comb begin
    w_par = 1'b0;
    case (r_mode)
      2'b00:   w_par = r_acc;
      2'b01:   w_par = ~r_acc;
      2'b10:   w_par = 1'b1;
      default: w_par = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_sr     <= '0;
      r_acc    <= 1'b0;
      r_cnt    <= '0;
      r_pbit   <= 1'b0;
      r_mode   <= 2'b00;
      r_parity <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_sr    <= i_word;
            r_pbit  <= i_parity_bit;
            r_mode  <= i_mode;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // All DATA_WIDTH bits have been folded in once the counter reaches
          // DATA_WIDTH; that cycle resolves the result and enters DONE.
          if (r_cnt == CW'(DATA_WIDTH)) begin
            r_parity <= w_par;
            r_error  <= w_par ^ r_pbit;
            r_state  <= S_DONE;
          end else begin
            r_acc <= r_acc ^ r_sr[0];
            r_sr  <= r_sr >> 1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (i_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic                     w_hs_err;

  assign w_hs_err    = (r_state == S_DONE) && i_ready && r_error;
  assign o_err_count = r_err_cnt;

  // Clear has priority over a coinciding increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_count)
      r_err_cnt <= '0;
    else if (w_hs_err && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = i_clr_count;
  assign o_err_count  = '0;
`endif

endmodule

// File: tb/tb_parity_unit.sv
// Directed testbench for parity_unit. Two instances share every input: the
// default configuration and one with a 2-bit error counter for saturation.
module tb_parity_unit;

`ifdef PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, vld_in, rdy_in, pbit, clr;
  logic [7:0] word;
  logic [1:0] mode;
  logic       rdy_out, vld_out, par, err;
  logic [7:0] cnt8;
  logic       rdy2, vld2, par2, err2;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp8  = 0;
  int exp2  = 0;

  always #5 clk = ~clk;

  parity_unit #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld_in), .o_ready(rdy_out),
    .i_word(word), .i_parity_bit(pbit), .i_mode(mode),
    .o_valid(vld_out), .i_ready(rdy_in), .o_parity(par), .o_error(err),
    .i_clr_count(clr), .o_err_count(cnt8)
  );

  parity_unit #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld_in), .o_ready(rdy2),
    .i_word(word), .i_parity_bit(pbit), .i_mode(mode),
    .o_valid(vld2), .i_ready(rdy_in), .o_parity(par2), .o_error(err2),
    .i_clr_count(clr), .o_err_count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready, take the acceptance edge, then scramble the inputs so any
  // leak into the word in flight shows up in the result.
  task automatic start_word(input logic [7:0] w, input logic p, input logic [1:0] m);
    int n;
    word = w; pbit = p; mode = m; vld_in = 1'b1;
    n = 0;
    while (!rdy_out && n < 50) begin tick(); n++; end
    if (n >= 50) chk("ready_timeout", 0, 1);
    tick();
    vld_in = 1'b0; word = ~w; pbit = ~p; mode = ~m;
  endtask

  task automatic wait_done(input logic ep, input logic ee);
    int n;
    n = 0;
    while (!vld_out && n < 50) begin tick(); n++; end
    chk("latency", n, 9);
    chk("parity", par, ep);
    chk("error", err, ee);
    chk("parity_w2", par2, ep);
  endtask

  task automatic handshake(input logic with_clr);
    logic e;
    e = err;
    rdy_in = 1'b1; clr = with_clr;
    tick();
    rdy_in = 1'b0; clr = 1'b0;
    if (CNT_EN) begin
      if (with_clr) begin exp8 = 0; exp2 = 0; end
      else if (e) begin
        if (exp8 < 255) exp8++;
        if (exp2 < 3) exp2++;
      end
    end
    chk("valid_after_hs", vld_out, 0);
    chk("ready_after_hs", rdy_out, 1);
    chk("cnt8", cnt8, exp8);
    chk("cnt2", cnt2, exp2);
  endtask

  initial begin
    rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b0; pbit = 1'b0; clr = 1'b0;
    word = '0; mode = 2'b00;
    tick(); tick();
    chk("rst_valid", vld_out, 0);
    chk("rst_parity", par, 0);
    chk("rst_error", err, 0);
    chk("rst_cnt", cnt8, 0);
    rst = 1'b0;
    chk("rst_ready", rdy_out, 1);

    // Even / odd / mark / space basics.
    start_word(8'b0000_0011, 1'b0, 2'b00); wait_done(1'b0, 1'b0); handshake(1'b0);
    start_word(8'h01, 1'b1, 2'b01);        wait_done(1'b0, 1'b1); handshake(1'b0);
    start_word(8'hFF, 1'b0, 2'b10);        wait_done(1'b1, 1'b1); handshake(1'b0);
    start_word(8'hFF, 1'b0, 2'b11);        wait_done(1'b0, 1'b0); handshake(1'b0);

    // Backpressure: hold the result while a second word is offered.
    start_word(8'h07, 1'b1, 2'b00);
    wait_done(1'b1, 1'b0);
    word = 8'h0F; pbit = 1'b0; mode = 2'b00; vld_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", vld_out, 1);
      chk("bp_parity", par, 1);
      chk("bp_error", err, 0);
      chk("bp_ready", rdy_out, 0);
    end
    handshake(1'b0);
    tick();
    chk("bp_accept2", rdy_out, 0);
    vld_in = 1'b0; word = 8'hF0; pbit = 1'b1; mode = 2'b10;
    wait_done(1'b0, 1'b0);
    handshake(1'b0);

    // Five error words: odd mode on zero, received 0.
    for (int i = 0; i < 5; i++) begin
      start_word(8'h00, 1'b0, 2'b01); wait_done(1'b1, 1'b1); handshake(1'b0);
    end
    chk("sat_cnt2", cnt2, CNT_EN ? 3 : 0);

    // Clear coinciding with an error handshake.
    start_word(8'h00, 1'b0, 2'b01); wait_done(1'b1, 1'b1); handshake(1'b1);
    chk("clr_cnt8", cnt8, 0);

    // Reset in the third SHIFT cycle discards the word and clears the count.
    start_word(8'h00, 1'b0, 2'b01); wait_done(1'b1, 1'b1); handshake(1'b0);
    start_word(8'h01, 1'b1, 2'b00);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp8 = 0; exp2 = 0;
    chk("mid_rst_valid", vld_out, 0);
    chk("mid_rst_ready", rdy_out, 1);
    chk("mid_rst_cnt8", cnt8, 0);
    chk("mid_rst_cnt2", cnt2, 0);
    for (int i = 0; i < 12; i++) tick();
    chk("mid_rst_no_result", vld_out, 0);

    // Walking-ones sweep: k set bits, even mode, received 0.
    for (int k = 1; k <= 8; k++) begin
      logic [8:0] w9;
      w9 = (9'd1 << k) - 9'd1;
      start_word(w9[7:0], 1'b0, 2'b00);
      wait_done(k[0], k[0]);
      handshake(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
